// File: rtl/condicionador_pkg.sv
// Shared definitions for the condicionador key/switch conditioner: per-channel
// FSM state encoding and the default stability window.
package condicionador_pkg;

    // 20 ms at 50 MHz.
    localparam int DEB_CYCLES_DEFAULT = 1000000;

    typedef enum logic [1:0] {
        STABLE_LO = 2'b00,
        WAIT_HI   = 2'b01,
        STABLE_HI = 2'b11,
        WAIT_LO   = 2'b10
    } estado_t;

endpackage

// File: rtl/condicionador_if.sv
// Raw key levels in, debounced levels and edge pulses out, one bit per channel.
interface condicionador_if #(
    parameter int N_IN = 4
);
    logic [N_IN-1:0] btn_in;
    logic [N_IN-1:0] level_out;
    logic [N_IN-1:0] rise_pulse;
    logic [N_IN-1:0] fall_pulse;

    modport master (output btn_in, input level_out, rise_pulse, fall_pulse);
    modport slave  (input btn_in, output level_out, rise_pulse, fall_pulse);
endinterface

// File: rtl/debounce_canal.sv
// Single debounce channel: two-flop synchronizer, four-state FSM and a
// stability counter; level and pulses are registered.
module debounce_canal
    import condicionador_pkg::*;
#(
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic CLOCK_50,
    input  logic reset,
    input  logic btn_in,
    output logic level_out,
    output logic rise_pulse,
    output logic fall_pulse
);
    localparam int               CNT_W    = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync_meta;
    logic             sync;
    estado_t          state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_d, rise_d, fall_d;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value, independent of statement order.
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            sync_meta  <= 1'b0;
            sync       <= 1'b0;
            state_q    <= STABLE_LO;
            cnt_q      <= '0;
            level_out  <= 1'b0;
            rise_pulse <= 1'b0;
            fall_pulse <= 1'b0;
        end else begin
            sync_meta  <= btn_in;
            sync       <= sync_meta;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            level_out  <= level_d;
            rise_pulse <= rise_d;
            fall_pulse <= fall_d;
        end
    end

    // NOTE: every output of this block gets a default first, so no path
    // through the case can leave a value unassigned and infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        level_d = level_out;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        unique case (state_q)
            STABLE_LO: begin
                if (sync) begin
                    state_d = WAIT_HI;
                    cnt_d   = '0;
                end
            end
            WAIT_HI: begin
                if (!sync) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    // Compared before incrementing, so the counter never wraps.
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                    level_d = 1'b1;
                    rise_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            STABLE_HI: begin
                if (!sync) begin
                    state_d = WAIT_LO;
                    cnt_d   = '0;
                end
            end
            WAIT_LO: begin
                if (sync) begin
                    state_d = STABLE_HI;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = STABLE_LO;
                    cnt_d   = '0;
                    level_d = 1'b0;
                    fall_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = STABLE_LO;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/condicionador.sv
// Conditioner top: N_IN independent debounce channels feeding counter
// control inputs with clean levels and single-cycle edge pulses.
module condicionador
    import condicionador_pkg::*;
#(
    parameter int N_IN       = 4,
    parameter int DEB_CYCLES = DEB_CYCLES_DEFAULT
) (
    input  logic           CLOCK_50,
    input  logic           reset,
    condicionador_if.slave bus
);

    for (genvar i = 0; i < N_IN; i++) begin : g_canal
        debounce_canal #(
            .DEB_CYCLES(DEB_CYCLES)
        ) u_canal (
            .CLOCK_50  (CLOCK_50),
            .reset     (reset),
            .btn_in    (bus.btn_in[i]),
            .level_out (bus.level_out[i]),
            .rise_pulse(bus.rise_pulse[i]),
            .fall_pulse(bus.fall_pulse[i])
        );
    end

endmodule

// File: tb/tb_condicionador.sv
// Bench for condicionador: run-length reference model compared every cycle,
// plus directed timing cases with literal expectations.
module tb_condicionador;
    localparam int N   = 4;
    localparam int DEB = 4;

    logic clock_novo;
    logic reset;
    logic chk_en;
    int   n_tests;
    int   n_fail;

    condicionador_if #(.N_IN(N)) bus ();

    condicionador #(
        .N_IN      (N),
        .DEB_CYCLES(DEB)
    ) dut (
        .CLOCK_50(clock_novo),
        .reset   (reset),
        .bus     (bus.slave)
    );

    initial clock_novo = 1'b0;
    always #10 clock_novo = ~clock_novo;

    task automatic check(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b, expected %b (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: a channel flips once the synchronized input has disagreed with
    // the debounced level on DEB+1 consecutive clock edges.
    logic [N-1:0] m_s1, m_s2, m_level, m_rise, m_fall;
    int           m_run[N];

    initial begin
        m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
        for (int i = 0; i < N; i++) m_run[i] = 0;
        forever begin
            @(posedge clock_novo);
            if (reset) begin
                m_s1 = '0; m_s2 = '0; m_level = '0; m_rise = '0; m_fall = '0;
                for (int i = 0; i < N; i++) m_run[i] = 0;
            end else begin
                m_rise = '0;
                m_fall = '0;
                for (int i = 0; i < N; i++) begin
                    if (m_s2[i] != m_level[i]) begin
                        m_run[i]++;
                        if (m_run[i] == DEB + 1) begin
                            m_level[i] = ~m_level[i];
                            if (m_level[i]) m_rise[i] = 1'b1;
                            else            m_fall[i] = 1'b1;
                            m_run[i] = 0;
                        end
                    end else begin
                        m_run[i] = 0;
                    end
                end
                m_s2 = m_s1;
                m_s1 = bus.btn_in;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clock_novo);
            if (chk_en) begin
                check("model level_out",  bus.level_out,  m_level);
                check("model rise_pulse", bus.rise_pulse, m_rise);
                check("model fall_pulse", bus.fall_pulse, m_fall);
            end
        end
    end

    task automatic step();
        @(posedge clock_novo);
        @(negedge clock_novo);
    endtask

    // Leaves the bench at a negedge with reset low; the next posedge is edge 1.
    task automatic do_reset();
        reset      = 1'b1;
        bus.btn_in = '0;
        step();
        step();
        reset = 1'b0;
    endtask

    int hold[N];

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        chk_en     = 1'b0;
        reset      = 1'b1;
        bus.btn_in = '0;
        step();
        step();
        chk_en = 1'b1;

        // Quiet inputs after reset: everything stays low.
        do_reset();
        for (int k = 1; k <= 20; k++) begin
            step();
            check("idle outputs", bus.level_out | bus.rise_pulse | bus.fall_pulse, 4'b0000);
        end

        // Single press on channel 0: level and pulse appear after edge 7.
        do_reset();
        bus.btn_in = 4'b0001;
        for (int k = 1; k <= 6; k++) begin
            step();
            check("press ch0 early level", bus.level_out, 4'b0000);
        end
        step();
        check("press ch0 level e7", bus.level_out,  4'b0001);
        check("press ch0 rise e7",  bus.rise_pulse, 4'b0001);
        step();
        check("press ch0 rise e8",  bus.rise_pulse, 4'b0000);
        check("press ch0 level e8", bus.level_out,  4'b0001);

        // Three-cycle bounce on channel 1 is swallowed.
        do_reset();
        bus.btn_in = 4'b0010;
        step(); step(); step();
        bus.btn_in = 4'b0000;
        for (int k = 1; k <= 12; k++) begin
            step();
            check("bounce ch1 level", bus.level_out,  4'b0000);
            check("bounce ch1 rise",  bus.rise_pulse, 4'b0000);
        end

        // Release on channel 2: fall pulse after edge k+6 (k = first low edge).
        do_reset();
        bus.btn_in = 4'b0100;
        for (int k = 1; k <= 10; k++) step();
        check("release ch2 settled", bus.level_out, 4'b0100);
        bus.btn_in = 4'b0000;
        for (int k = 1; k <= 6; k++) step();
        check("release ch2 level e6", bus.level_out,  4'b0100);
        check("release ch2 fall e6",  bus.fall_pulse, 4'b0000);
        step();
        check("release ch2 fall e7",  bus.fall_pulse, 4'b0100);
        check("release ch2 level e7", bus.level_out,  4'b0000);
        step();
        check("release ch2 fall e8",  bus.fall_pulse, 4'b0000);

        // Reset at edge 5 aborts the window; new rise after edge 12.
        do_reset();
        bus.btn_in = 4'b0001;
        for (int k = 1; k <= 4; k++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        for (int k = 6; k <= 11; k++) begin
            step();
            check("reset abort rise", bus.rise_pulse, 4'b0000);
            check("reset abort level", bus.level_out, 4'b0000);
        end
        step();
        check("reset rerun rise e12",  bus.rise_pulse, 4'b0001);
        check("reset rerun level e12", bus.level_out,  4'b0001);

        // All channels pressed together pulse together.
        do_reset();
        bus.btn_in = 4'b1111;
        for (int k = 1; k <= 6; k++) step();
        check("all rise e6", bus.rise_pulse, 4'b0000);
        step();
        check("all rise e7",  bus.rise_pulse, 4'b1111);
        check("all level e7", bus.level_out,  4'b1111);
        step();
        check("all rise e8", bus.rise_pulse, 4'b0000);

        // Random bursts of varying length, occasional reset.
        do_reset();
        for (int i = 0; i < N; i++) hold[i] = $urandom_range(1, 9);
        for (int c = 0; c < 2000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (hold[i] == 0) begin
                    bus.btn_in[i] = ~bus.btn_in[i];
                    hold[i] = ($urandom_range(0, 3) == 0) ? $urandom_range(10, 30)
                                                          : $urandom_range(1, 9);
                end else begin
                    hold[i]--;
                end
            end
            reset = ($urandom_range(0, 249) == 0);
            step();
        end
        reset = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
